// File: rtl/freq_scan_pkg.sv
// freq_scan_pkg: FSM state type and symbol-table geometry shared by freq_table_scanner.
package freq_scan_pkg;
    localparam int SYM_W   = 8;
    localparam int NUM_SYM = 256;
    typedef enum logic [1:0] {IDLE, SCAN, EMIT, DONE} state_t;
endpackage

// File: rtl/pulse_edge_detect.sv
// pulse_edge_detect: rising-edge detector on a level input.
//   clk      in  clock, rising edge
//   reset_n  in  asynchronous active-low reset
//   i_sig    in  level signal
//   o_rise   out high for the cycle where i_sig is high and was low at the previous edge
module pulse_edge_detect (
    input  logic clk,
    input  logic reset_n,
    input  logic i_sig,
    output logic o_rise
);
    logic r_sig_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_sig_d <= 1'b0;
        else          r_sig_d <= i_sig;
    end

    // The delayed copy resets low, so a level already high at reset release reads as an edge.
    assign o_rise = i_sig & ~r_sig_d;
endmodule

// File: rtl/freq_table_scanner.sv
// freq_table_scanner: streams (symbol, frequency) pairs from a 256-entry table and totals it.
//   clk, reset_n          clock and asynchronous active-low reset
//   start                 level request, a rising edge in IDLE starts one scan
//   addr / freq_in        table read port, data combinational from addr
//   out_valid/out_ready   pair handshake carrying out_symbol, out_freq, out_last
//   busy / done           scan in progress / scan complete (held until start drops)
//   nz_count / total      emitted pairs and sum of all entries, final while done is high
module freq_table_scanner
    import freq_scan_pkg::*;
#(
    parameter int FREQ_W    = 24,
    parameter int TOTAL_W   = 32,
    parameter bit SKIP_ZERO = 1'b1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    output logic [SYM_W-1:0]   addr,
    input  logic [FREQ_W-1:0]  freq_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [SYM_W-1:0]   out_symbol,
    output logic [FREQ_W-1:0]  out_freq,
    output logic               out_last,
    output logic               busy,
    output logic               done,
    output logic [8:0]         nz_count,
    output logic [TOTAL_W-1:0] total
);
    localparam logic [SYM_W:0] LP_END = (SYM_W+1)'(NUM_SYM);

    state_t              r_state, w_next;
    logic [SYM_W:0]      r_idx, w_idx_inc;
    logic                r_h_valid;
    logic [SYM_W-1:0]    r_h_sym, r_o_sym;
    logic [FREQ_W-1:0]   r_h_freq, r_o_freq;
    logic                r_o_last;
    logic [8:0]          r_nz;
    logic [TOTAL_W-1:0]  r_total;
    logic                w_start_rise, w_qual;
    logic                w_clr, w_inc, w_load_h, w_clr_h, w_load_o, w_o_from_in, w_o_last;

    pulse_edge_detect u_start_edge (
        .clk     (clk),
        .reset_n (reset_n),
        .i_sig   (start),
        .o_rise  (w_start_rise)
    );

    assign w_idx_inc = r_idx + 1'b1;
    assign w_qual    = (freq_in != '0) || !SKIP_ZERO;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_next;
    end

    // H holds the most recent qualifying entry; it is only released to O once a successor
    // is found or the table is exhausted, which is how out_last is known in advance.
    always_comb begin
        w_next      = r_state;
        w_clr       = 1'b0;
        w_inc       = 1'b0;
        w_load_h    = 1'b0;
        w_clr_h     = 1'b0;
        w_load_o    = 1'b0;
        w_o_from_in = 1'b0;
        w_o_last    = 1'b0;
        case (r_state)
            IDLE: if (w_start_rise) begin
                w_clr  = 1'b1;
                w_next = SCAN;
            end
            SCAN: begin
                w_inc = 1'b1;
                if (w_qual && r_h_valid) begin
                    w_load_o = 1'b1;
                    w_load_h = 1'b1;
                    w_next   = EMIT;
                end else if (w_idx_inc == LP_END) begin
                    // The final qualifying entry may be the one on the bus right now.
                    if (w_qual || r_h_valid) begin
                        w_load_o    = 1'b1;
                        w_o_from_in = w_qual;
                        w_o_last    = 1'b1;
                        w_clr_h     = 1'b1;
                        w_next      = EMIT;
                    end else begin
                        w_next = DONE;
                    end
                end else if (w_qual) begin
                    w_load_h = 1'b1;
                end
            end
            EMIT: if (out_ready) begin
                if (r_o_last) begin
                    w_next = DONE;
                end else if (r_idx == LP_END) begin
                    if (r_h_valid) begin
                        w_load_o = 1'b1;
                        w_o_last = 1'b1;
                        w_clr_h  = 1'b1;
                    end else begin
                        w_next = DONE;
                    end
                end else begin
                    w_next = SCAN;
                end
            end
            DONE:    if (!start) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_idx     <= '0;
            r_total   <= '0;
            r_nz      <= '0;
            r_h_valid <= 1'b0;
            r_h_sym   <= '0;
            r_h_freq  <= '0;
            r_o_sym   <= '0;
            r_o_freq  <= '0;
            r_o_last  <= 1'b0;
        end else begin
            if (w_clr) begin
                r_idx   <= '0;
                r_total <= '0;
                r_nz    <= '0;
            end else if (w_inc) begin
                r_idx   <= w_idx_inc;
                r_total <= r_total + TOTAL_W'(freq_in);
                if (w_qual) r_nz <= r_nz + 1'b1;
            end
            if (w_clr || w_clr_h) r_h_valid <= 1'b0;
            else if (w_load_h)    r_h_valid <= 1'b1;
            if (w_load_h) begin
                r_h_sym  <= addr;
                r_h_freq <= freq_in;
            end
            if (w_load_o) begin
                r_o_sym  <= w_o_from_in ? addr : r_h_sym;
                r_o_freq <= w_o_from_in ? freq_in : r_h_freq;
                r_o_last <= w_o_last;
            end
        end
    end

    assign addr       = r_idx[SYM_W-1:0];
    assign out_valid  = (r_state == EMIT);
    assign out_symbol = r_o_sym;
    assign out_freq   = r_o_freq;
    assign out_last   = r_o_last;
    assign busy       = (r_state == SCAN) || (r_state == EMIT);
    assign done       = (r_state == DONE);
    assign nz_count   = r_nz;
    assign total      = r_total;
endmodule

// File: tb/tb_freq_table_scanner.sv
// tb_freq_table_scanner: scoreboard bench for freq_table_scanner.
module tb_freq_table_scanner;
    logic        clk = 1'b0;
    logic        reset_n, start, out_ready;
    logic [7:0]  addr, out_symbol;
    logic [23:0] freq_in, out_freq;
    logic        out_valid, out_last, busy, done;
    logic [8:0]  nz_count;
    logic [31:0] total;

    typedef struct packed {
        logic [7:0]  sym;
        logic [23:0] freq;
        logic        last;
    } pair_t;

    logic [23:0] mem [256];
    pair_t       exp_q [$];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;
    assign freq_in = mem[addr];

    freq_table_scanner #(.FREQ_W(24), .TOTAL_W(32), .SKIP_ZERO(1'b1)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .addr       (addr),
        .freq_in    (freq_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_symbol (out_symbol),
        .out_freq   (out_freq),
        .out_last   (out_last),
        .busy       (busy),
        .done       (done),
        .nz_count   (nz_count),
        .total      (total)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = '0;
    endtask

    task automatic load_basic();
        clear_mem();
        mem[8'h00] = 24'd405;
        mem[8'h01] = 24'd41;
        mem[8'h05] = 24'd8;
    endtask

    task automatic end_scan();
        start = 1'b0;
        tick();
        tick();
    endtask

    // Raises start, pushes the expected stream from the table model, then pops and
    // compares every transferred pair. stall>0 holds out_ready low on the first pair;
    // glitch_at>0 pulses start low/high at that cycle while the scan is running.
    task automatic drive_scan(input int stall, input int glitch_at);
        int          last_nz = -1;
        int          cyc = 0;
        int          left = stall;
        int          exp_nz = 0;
        logic [31:0] exp_total = '0;
        logic [7:0]  held_addr = '0;
        pair_t       got, held, exp;
        bit          have = 1'b0;
        held = '0;
        exp_q.delete();
        for (int i = 0; i < 256; i++) if (mem[i] != 0) last_nz = i;
        for (int i = 0; i < 256; i++) begin
            exp_total += 32'(mem[i]);
            if (mem[i] != 0) begin
                exp_nz++;
                exp_q.push_back({8'(i), mem[i], i == last_nz});
            end
        end
        out_ready = (stall == 0);
        start = 1'b1;
        while (done !== 1'b1 && cyc < 3000) begin
            tick();
            cyc++;
            if (cyc == glitch_at) begin
                checks++;
                if (busy !== 1'b1) begin
                    errors++;
                    $display("FAIL glitch_busy got %b want 1", busy);
                end
                start = 1'b0;
            end
            if (cyc == glitch_at + 1) start = 1'b1;
            if (out_valid === 1'b1) begin
                got = {out_symbol, out_freq, out_last};
                if (left > 0) begin
                    if (!have) begin
                        held = got;
                        held_addr = addr;
                        have = 1'b1;
                    end else begin
                        checks++;
                        if (got !== held || addr !== held_addr) begin
                            errors++;
                            $display("FAIL stall_hold got %h/%h want %h/%h", got, addr, held, held_addr);
                        end
                    end
                    left--;
                    if (left == 0) out_ready = 1'b1;
                end
                if (out_ready) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL extra_pair got sym=%h freq=%0d last=%b want none", got.sym, got.freq, got.last);
                    end else begin
                        exp = exp_q.pop_front();
                        if (got !== exp) begin
                            errors++;
                            $display("FAIL pair got sym=%h freq=%0d last=%b want sym=%h freq=%0d last=%b",
                                     got.sym, got.freq, got.last, exp.sym, exp.freq, exp.last);
                        end
                    end
                end
            end
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL scan_timeout got done=%b want 1 within 3000 cycles", done);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_pairs got %0d left want 0", exp_q.size());
        end
        checks++;
        if (nz_count !== 9'(exp_nz) || total !== exp_total) begin
            errors++;
            $display("FAIL model_counts got nz=%0d total=%0d want nz=%0d total=%0d", nz_count, total, exp_nz, exp_total);
        end
    endtask

    task automatic check_counts(input string name, input logic [8:0] nz, input logic [31:0] tot);
        checks++;
        if (nz_count !== nz || total !== tot || done !== 1'b1) begin
            errors++;
            $display("FAIL %s got nz=%0d total=%0d done=%b want nz=%0d total=%0d done=1", name, nz_count, total, done, nz, tot);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        start = 1'b0;
        out_ready = 1'b1;
        clear_mem();
        repeat (3) tick();
        checks++;
        if ({addr, out_valid, out_symbol, out_freq, out_last, busy, done, nz_count, total} !== '0) begin
            errors++;
            $display("FAIL reset_values got addr=%h v=%b sym=%h f=%h l=%b busy=%b done=%b nz=%h tot=%h want all 0",
                     addr, out_valid, out_symbol, out_freq, out_last, busy, done, nz_count, total);
        end
        reset_n = 1'b1;
        repeat (3) tick();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset got busy=%b done=%b want 0 0", busy, done);
        end
    endtask

    task automatic test_basic();
        load_basic();
        drive_scan(0, 0);
        check_counts("basic_counts", 9'd3, 32'd454);
        end_scan();
    endtask

    task automatic test_all_zero();
        bit bad = 1'b0;
        clear_mem();
        start = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b1 || addr !== 8'h00) begin
            errors++;
            $display("FAIL zero_first_scan got busy=%b addr=%h want 1 00", busy, addr);
        end
        for (int k = 1; k <= 255; k++) begin
            tick();
            if (out_valid !== 1'b0 || done !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad || addr !== 8'hFF) begin
            errors++;
            $display("FAIL zero_scan_run got early_valid_or_done=%b addr=%h want 0 ff", bad, addr);
        end
        tick();
        check_counts("zero_done", 9'd0, 32'd0);
        end_scan();
    endtask

    task automatic test_last_symbol();
        bit bad = 1'b0;
        clear_mem();
        mem[8'hFF] = 24'd7;
        drive_scan(0, 0);
        check_counts("last_sym_counts", 9'd1, 32'd7);
        repeat (10) begin
            tick();
            if (done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL no_wrap got rescan_activity=1 want 0");
        end
        end_scan();
    endtask

    task automatic test_backpressure();
        clear_mem();
        mem[8'h10] = 24'd3;
        mem[8'h20] = 24'd9;
        drive_scan(10, 0);
        check_counts("stall_counts", 9'd2, 32'd12);
        end_scan();
    endtask

    task automatic test_start_handling();
        bit bad = 1'b0;
        load_basic();
        drive_scan(0, 20);
        check_counts("glitch_counts", 9'd3, 32'd454);
        repeat (20) begin
            tick();
            if (done !== 1'b1 || busy !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL held_start got restart=1 want 0");
        end
        end_scan();
        drive_scan(0, 0);
        check_counts("restart_counts", 9'd3, 32'd454);
        end_scan();
    endtask

    task automatic test_reset_emit();
        load_basic();
        out_ready = 1'b0;
        start = 1'b1;
        for (int i = 0; i < 50 && out_valid !== 1'b1; i++) tick();
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL reach_emit got out_valid=%b want 1", out_valid);
        end
        #2;
        reset_n = 1'b0;
        start = 1'b0;
        #1;
        checks++;
        if ({addr, out_valid, out_symbol, out_freq, out_last, busy, done, nz_count, total} !== '0) begin
            errors++;
            $display("FAIL async_reset got addr=%h v=%b sym=%h f=%h l=%b busy=%b done=%b nz=%h tot=%h want all 0",
                     addr, out_valid, out_symbol, out_freq, out_last, busy, done, nz_count, total);
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (5) tick();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || out_valid !== 1'b0 || addr !== 8'h00) begin
            errors++;
            $display("FAIL idle_after_reset_emit got busy=%b done=%b v=%b addr=%h want 0 0 0 00", busy, done, out_valid, addr);
        end
        drive_scan(0, 0);
        check_counts("post_reset_counts", 9'd3, 32'd454);
        end_scan();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_all_zero();
        test_last_symbol();
        test_backpressure();
        test_start_handling();
        test_reset_emit();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/freq_table_scanner.md
# freq_table_scanner

Reads back the 256-entry symbol frequency table produced by the compression front end and streams every non-zero (symbol, frequency) pair, in ascending symbol order, to the Huffman codebook builder over a valid/ready interface. Drives the table's read address, samples the combinational read data, and accumulates the table's total count and number of used symbols. Sits between the frequency counting stage and codebook generation; the table must not be written while a scan is running.

## Interface
- `FREQ_W`, 24: width of one frequency entry.
- `TOTAL_W`, 32: width of the total accumulator; must be ≥ FREQ_W+8, so no overflow is possible.
- `SKIP_ZERO`, 1: 1 emits only non-zero entries; 0 emits all 256.

- `clk`  in  1  single clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  level request; a rising edge starts one scan.
- `addr`  out  8  table read address.
- `freq_in`  in  FREQ_W  table read data; combinational from `addr`, same cycle.
- `out_valid`  out  1  output pair valid.
- `out_ready`  in  1  consumer accepts the pair.
- `out_symbol`  out  8  symbol of the pair.
- `out_freq`  out  FREQ_W  frequency of the pair.
- `out_last`  out  1  final pair of this scan.
- `busy`  out  1  scan in progress.
- `done`  out  1  scan complete; held until `start` is low.
- `nz_count`  out  9  number of emitted pairs (0..256).
- `total`  out  TOTAL_W  sum of all 256 entries.

## Operation
- Rising-edge detection on `start` uses `start_d`, which resets to 0.
  - If `start` is high when `reset_n` releases, that counts as one rising edge.
  - A rising edge is ignored unless the FSM is in IDLE.
- Internal 9-bit index `idx`; `addr = idx[7:0]`. The scan ends when `idx` reaches 256, so there is no wrap ambiguity.
- Internal registers:
  - hold register H: `h_valid`, `h_sym`, `h_freq`.
  - output register O: drives `out_*`.
- FSM states: IDLE, SCAN, EMIT, DONE.
- **IDLE**: on a start edge, clear `idx`, `total`, `nz_count` and `h_valid`, then go to SCAN.
- **SCAN**, one address per cycle:
  - Always: `total += freq_in`.
  - If the entry qualifies (`freq_in != 0`, or `SKIP_ZERO == 0`):
    - `nz_count++`.
    - If `h_valid`: load O ← H with last=0, load H ← (addr, freq_in), go to EMIT.
    - Else: load H ← (addr, freq_in).
  - Always: `idx++`.
  - When `idx == 256` is reached without a pending EMIT:
    - if `h_valid`: load O ← H with last=1, clear `h_valid`, go to EMIT.
    - else: go to DONE.
- **EMIT**:
  - `out_valid = 1`; `idx` and `addr` are frozen.
  - A transfer occurs on a clock edge where `out_valid && out_ready`.
  - After a transfer: if `out_last`, go to DONE. Otherwise, if `idx == 256`, run the end-of-scan rule above; else return to SCAN.
- **DONE**: `done = 1`; `nz_count` and `total` stay valid. When `start == 0`, go to IDLE.
- Reset mid-operation: every register clears immediately and the FSM returns to IDLE. No partial pair is flushed.

## Timing
- Reset values:
  - `addr`, `out_symbol`, `out_freq`, `nz_count`, `total`: 0.
  - `out_valid`, `out_last`, `busy`, `done`: 0.
- `busy` is high in SCAN and EMIT.
- The start edge is sampled on clock edge E; the first SCAN cycle is E+1 with `addr = 0`.
- All-zero table: SCAN runs for cycles E+1..E+256; `done` rises at E+257.
- Each emitted pair costs at least one EMIT cycle plus the SCAN cycle of its successor.
- While `out_valid && !out_ready`, `out_symbol`, `out_freq`, `out_last` and `addr` are held stable.
- `out_valid` never deasserts without a transfer, except on reset.
- `nz_count` and `total` are final only when `done` is high.

## Structure
- Package `freq_scan_pkg` holds:
  - the FSM state enum (IDLE, SCAN, EMIT, DONE);
  - the constants `SYM_W = 8` and `NUM_SYM = 256`.
- One sub-module, `pulse_edge_detect`: registered rising-edge detector with async active-low reset, used for `start`.
- Everything else lives in one FSM plus a datapath block.

## Test plan
- Table {0x00:405, 0x01:41, 0x05:8}, rest 0, `out_ready = 1`:
  - pairs (0x00,405,0), (0x01,41,0), (0x05,8,1);
  - `nz_count = 3`, `total = 454`, `done` high.
- All-zero table:
  - `out_valid` never asserts;
  - `done` at E+257 with `nz_count = 0`, `total = 0`.
- Only 0xFF = 7:
  - single pair (0xFF,7,last=1);
  - `nz_count = 1`, `total = 7`; no address wrap.
- Table {0x10:3, 0x20:9}, `out_ready` low for 10 cycles while the first pair is valid:
  - the (0x10,3) pair and `addr` stay stable;
  - after release, both pairs complete in order.
- Start handling:
  - a start edge during SCAN is ignored;
  - `start` held high after `done`: no restart;
  - drop `start` then raise it again: a new scan runs with counters cleared and an identical stream.
- Reset during EMIT:
  - `reset_n` low mid-stream clears all outputs to 0 asynchronously;
  - after release the FSM sits in IDLE until a new start edge.
